// File: rtl/shift_ctrl_pkg.sv
// Shared types and defaults for the tapped shift-register sequencing controller.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 64;
    localparam int DEF_TAP1  = 16;
    localparam int DEF_TAP2  = 32;
    localparam int DEF_TAP3  = 48;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/shift_valid_tracker.sv
// Per-stage valid shadow of the data shift register plus a running count of real samples.
module shift_valid_tracker
    import shift_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAP1  = DEF_TAP1,
    parameter int TAP2  = DEF_TAP2,
    parameter int TAP3  = DEF_TAP3,
    parameter int OCC_W = occ_w(DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift,
    input  logic             ins,
    output logic             out_valid,
    output logic [2:0]       tap_valid,
    output logic [OCC_W-1:0] occupancy,
    output logic             empty,
    output logic             lower_empty
);

    logic [DEPTH-1:0] valid_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_vec <= '0;
            occupancy <= '0;
        end else if (shift) begin
            valid_vec <= {valid_vec[DEPTH-2:0], ins};
            // A sample entering while one leaves keeps the count; otherwise +/-1.
            if (ins && !out_valid)
                occupancy <= occupancy + OCC_W'(1);
            else if (!ins && out_valid)
                occupancy <= occupancy - OCC_W'(1);
        end
    end

    assign out_valid   = valid_vec[DEPTH-1];
    assign tap_valid   = {valid_vec[TAP3-1], valid_vec[TAP2-1], valid_vec[TAP1-1]};
    assign empty       = (valid_vec == '0);
    // Only the output stage may still be real: one more drain shift empties everything.
    assign lower_empty = (valid_vec[DEPTH-2:0] == '0);

endmodule

// File: rtl/shift_8x64_seq_ctrl.sv
// Sequencing controller for the 8x64 tapped shift register: input handshake,
// output backpressure, occupancy tracking and a bubble-free flush.
module shift_8x64_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAP1  = DEF_TAP1,
    parameter int TAP2  = DEF_TAP2,
    parameter int TAP3  = DEF_TAP3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic                     flush_req,
    output logic                     flush_busy,
    output logic                     flush_done,
    output logic                     shift,
    output logic [WIDTH-1:0]         sr_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               tap_valid,
    output logic [occ_w(DEPTH)-1:0]  occupancy
);

    generate
        if (!(1 <= TAP1 && TAP1 < TAP2 && TAP2 < TAP3 && TAP3 < DEPTH)) begin : g_bad_taps
            $error("shift_8x64_seq_ctrl: taps must satisfy 1 <= TAP1 < TAP2 < TAP3 < DEPTH");
        end
    endgenerate

    state_t state;
    logic   ins, adv, empty, lower_empty;

    // A real sr_out sample may only be shifted out if downstream takes it.
    assign adv        = !out_valid || out_ready;
    assign flush_busy = (state == FLUSH);

    always_comb begin
        shift    = 1'b0;
        in_ready = 1'b0;
        sr_in    = '0;
        ins      = 1'b0;
        case (state)
            RUN: begin
                in_ready = adv;
                shift    = in_valid && adv;
                sr_in    = in_data;
                ins      = 1'b1;
            end
            FLUSH:   shift = adv && !empty;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_req)   state <= FLUSH;
                    else if (enable) state <= RUN;
                end
                RUN: begin
                    if (flush_req)    state <= FLUSH;
                    else if (!enable) state <= IDLE;
                end
                FLUSH: begin
                    // Leave on the edge that drains the last sample so no idle FLUSH cycle follows.
                    if (empty || (shift && lower_empty)) begin
                        state      <= IDLE;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    shift_valid_tracker #(
        .DEPTH (DEPTH),
        .TAP1  (TAP1),
        .TAP2  (TAP2),
        .TAP3  (TAP3),
        .OCC_W (occ_w(DEPTH))
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift       (shift),
        .ins         (ins),
        .out_valid   (out_valid),
        .tap_valid   (tap_valid),
        .occupancy   (occupancy),
        .empty       (empty),
        .lower_empty (lower_empty)
    );

endmodule
